// File: rtl/alu_dispatch.sv
// Front-end sequencer for the 8-bit ALU. It accepts one op, pulses the chosen unit's
// start, waits for its done or a timeout, and holds the result until it is consumed.
module alu_dispatch #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic [3:0]  unit_start,
    output logic [7:0]  unit_a,
    output logic [7:0]  unit_b,
    input  logic [3:0]  unit_done,
    input  logic [63:0] unit_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [1:0]  out_op,
    output logic        out_zero,
    output logic        out_neg,
    output logic        out_timeout
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t        state;
    logic [1:0]    op;
    logic [CW-1:0] count;
    logic [15:0]   sel_result;
    logic          sel_done;

    // Only the selected unit's done/result slice is ever looked at.
    always_comb begin
        sel_result = unit_result[{op, 4'b0000} +: 16];
        sel_done   = unit_done[op];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            op          <= 2'b00;
            count       <= '0;
            unit_start  <= 4'b0000;
            unit_a      <= 8'h00;
            unit_b      <= 8'h00;
            out_valid   <= 1'b0;
            out_result  <= 16'h0000;
            out_op      <= 2'b00;
            out_zero    <= 1'b0;
            out_neg     <= 1'b0;
            out_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    // in_ready is still low on the first edge after reset release
                    if (in_ready && in_valid) begin
                        in_ready   <= 1'b0;
                        op         <= in_op;
                        unit_a     <= in_a;
                        unit_b     <= in_b;
                        unit_start <= 4'(4'b0001 << in_op);
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    unit_start <= 4'b0000;
                    count      <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (sel_done) begin
                        out_result  <= sel_result;
                        out_zero    <= (sel_result == 16'h0000);
                        out_neg     <= sel_result[15];
                        out_timeout <= 1'b0;
                        out_op      <= op;
                        out_valid   <= 1'b1;
                        state       <= HOLD;
                    end else if (count == CW'(TIMEOUT_CYCLES - 1)) begin
                        out_result  <= 16'h0000;
                        out_zero    <= 1'b0;
                        out_neg     <= 1'b0;
                        out_timeout <= 1'b1;
                        out_op      <= op;
                        out_valid   <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch: add/sub units are two-edge behavioural models,
// mul/div done and result are driven by hand to reach timeout and stale-done cases.
module tb_alu_dispatch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [1:0]  in_op;
    logic [7:0]  in_a, in_b;
    logic [3:0]  unit_start;
    logic [7:0]  unit_a, unit_b;
    logic [3:0]  unit_done;
    logic [63:0] unit_result;
    logic        out_valid, out_ready;
    logic [15:0] out_result;
    logic [1:0]  out_op;
    logic        out_zero, out_neg, out_timeout;

    logic        add_stg = 1'b0, add_done = 1'b0, sub_stg = 1'b0, sub_done = 1'b0;
    logic [15:0] add_res = '0, sub_res = '0, mul_res, div_res;
    logic [1:0]  man_done;

    int checks = 0;
    int errors = 0;
    int n;
    logic [15:0] held;

    always #5 clk = ~clk;

    alu_dispatch #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .unit_start(unit_start),
        .unit_a(unit_a), .unit_b(unit_b), .unit_done(unit_done),
        .unit_result(unit_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_op(out_op), .out_zero(out_zero),
        .out_neg(out_neg), .out_timeout(out_timeout)
    );

    // Two-edge add/sub units: start sampled, then done one cycle later.
    always @(posedge clk) begin
        add_stg  <= unit_start[0];
        add_done <= add_stg;
        sub_stg  <= unit_start[1];
        sub_done <= sub_stg;
        if (unit_start[0]) add_res <= {{8{unit_a[7]}}, unit_a} + {{8{unit_b[7]}}, unit_b};
        if (unit_start[1]) sub_res <= {{8{unit_a[7]}}, unit_a} - {{8{unit_b[7]}}, unit_b};
    end

    assign unit_done   = {man_done, sub_done, add_done};
    assign unit_result = {div_res, mul_res, sub_res, add_res};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one op: returns in the first WAIT cycle.
    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        step();
        in_valid = 1'b0;
        chk("start_onehot", 32'(unit_start), 32'(4'b0001 << op));
        chk("ready_low_issue", 32'(in_ready), 32'd0);
        step();
        chk("start_one_cycle", 32'(unit_start), 32'd0);
        chk("unit_a_latched", 32'(unit_a), 32'(a));
        chk("unit_b_latched", 32'(unit_b), 32'(b));
    endtask

    // Count cycles until out_valid, bounded.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            step();
            cyc++;
        end
        if (!out_valid) chk("wait_timeout_bound", 32'(out_valid), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [15:0] r, input logic [1:0] op,
                                input logic z, input logic ng, input logic to);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_result"}, 32'(out_result), 32'(r));
        chk({tag, "_op"}, 32'(out_op), 32'(op));
        chk({tag, "_zero"}, 32'(out_zero), 32'(z));
        chk({tag, "_neg"}, 32'(out_neg), 32'(ng));
        chk({tag, "_timeout"}, 32'(out_timeout), 32'(to));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = 8'h00; in_b = 8'h00;
        out_ready = 1'b0; man_done = 2'b00; mul_res = 16'h1234; div_res = 16'h0000;
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_start", 32'(unit_start), 32'd0);
        chk("rst_unit_a", 32'(unit_a), 32'd0);
        chk("rst_result", 32'(out_result), 32'd0);
        chk("rst_flags", 32'({out_zero, out_neg, out_timeout, out_op}), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_ready", 32'(in_ready), 32'd1);

        // 1: add 5+3 with out_ready held high
        out_ready = 1'b1;
        issue(2'b00, 8'd5, 8'd3);
        wait_valid(n);
        chk("add_latency", 32'(n), 32'd2);
        check_result("add", 16'd8, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        chk("add_consumed", 32'(out_valid), 32'd0);
        chk("add_ready_again", 32'(in_ready), 32'd1);

        // 2: sub 3-10 = -7
        issue(2'b01, 8'd3, 8'd10);
        wait_valid(n);
        check_result("sub", 16'hFFF9, 2'b01, 1'b0, 1'b1, 1'b0);
        step();

        // 3: -4 + 4 = 0
        issue(2'b00, 8'hFC, 8'd4);
        wait_valid(n);
        check_result("zero", 16'h0000, 2'b00, 1'b1, 1'b0, 1'b0);
        step();

        // 4: div never finishes; a mul done mid-wait must be ignored
        out_ready = 1'b0;
        issue(2'b11, 8'd9, 8'd0);
        man_done = 2'b01;
        step();
        man_done = 2'b00;
        wait_valid(n);
        chk("timeout_wait_cycles", 32'(n + 1), 32'd64);
        check_result("tmo", 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1);
        div_res = 16'h0005; man_done = 2'b10;
        step();
        man_done = 2'b00;
        chk("late_done_result", 32'(out_result), 32'd0);
        chk("late_done_timeout", 32'(out_timeout), 32'd1);
        out_ready = 1'b1;
        step();
        chk("tmo_consumed", 32'(out_valid), 32'd0);

        // done in the last WAIT cycle beats the timeout
        issue(2'b11, 8'd1, 8'd1);
        for (int i = 0; i < 63; i++) step();
        chk("last_cycle_no_valid", 32'(out_valid), 32'd0);
        div_res = 16'h0042; man_done = 2'b10;
        step();
        man_done = 2'b00;
        check_result("lastdone", 16'h0042, 2'b11, 1'b0, 1'b0, 1'b0);
        step();

        // 5: backpressure with a pending request
        out_ready = 1'b0;
        issue(2'b00, 8'h80, 8'h80);
        wait_valid(n);
        check_result("bp", 16'hFF00, 2'b00, 1'b0, 1'b1, 1'b0);
        held = out_result;
        in_valid = 1'b1; in_op = 2'b00; in_a = 8'd1; in_b = 8'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid_held", 32'(out_valid), 32'd1);
            chk("bp_result_held", 32'(out_result), 32'(held));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_released", 32'(out_valid), 32'd0);
        chk("bp_not_accepted", 32'(unit_start), 32'd0);
        chk("bp_ready_idle", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_accepted", 32'(unit_start), 32'd1);
        wait_valid(n);
        check_result("bp2", 16'd2, 2'b00, 1'b0, 1'b0, 1'b0);
        step();

        // 6: reset during mul wait, then a stale mul done
        issue(2'b10, 8'd6, 8'd7);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_ready", 32'(in_ready), 32'd0);
        step();
        chk("rst_rel_ready", 32'(in_ready), 32'd1);
        mul_res = 16'h002A; man_done = 2'b01;
        step();
        man_done = 2'b00;
        chk("stale_no_valid", 32'(out_valid), 32'd0);
        chk("stale_no_start", 32'(unit_start), 32'd0);
        chk("stale_ready", 32'(in_ready), 32'd1);
        issue(2'b00, 8'd7, 8'hFE);
        wait_valid(n);
        chk("post_rst_latency", 32'(n), 32'd2);
        check_result("post_rst", 16'd5, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        chk("post_rst_consumed", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
